// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Purpose  : Owns the architectural fetch PC and issues word-aligned
//             instruction-memory reads at PC, PC+4, PC+8, ... The in-order
//             responses are collected in a small circular fetch buffer and
//             handed to decode as {pc, instr} over a valid/ready handshake.
//             An EX redirect flushes the buffer and loads a new PC. Responses
//             still in flight at that point are counted and discarded when
//             they arrive.
//  Ports    : clk, rst_n                    clock, synchronous active-low reset
//             imem_req_valid/ready/addr     instruction fetch request
//             imem_resp_valid/data          in-order fetch response
//             redirect_valid/target         branch/jump redirect from EX
//             id_valid/ready, id_pc/instr   decode-side output handshake
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH_SUM = DEPTH[c_CNT_W:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]                r_pc_q,        w_pc_d;
    logic [DEPTH-1:0][31:0]     r_buf_pc_q,    w_buf_pc_d;
    logic [DEPTH-1:0][31:0]     r_buf_instr_q, w_buf_instr_d;
    logic [DEPTH-1:0]           r_buf_fill_q,  w_buf_fill_d;
    logic [c_PTR_W-1:0]         r_alloc_ptr_q, w_alloc_ptr_d;
    logic [c_PTR_W-1:0]         r_fill_ptr_q,  w_fill_ptr_d;
    logic [c_PTR_W-1:0]         r_head_ptr_q,  w_head_ptr_d;
    logic [c_CNT_W-1:0]         r_alloc_cnt_q, w_alloc_cnt_d;
    // Allocated entries whose response has not arrived yet.
    logic [c_CNT_W-1:0]         r_pend_cnt_q,  w_pend_cnt_d;
    // Responses still owed by memory for requests made before a redirect.
    logic [c_CNT_W-1:0]         r_drop_cnt_q,  w_drop_cnt_d;

    logic [c_CNT_W:0]           w_occupancy;
    logic [c_CNT_W-1:0]         w_outstanding;
    logic                       w_accept;
    logic                       w_pop;
    logic                       w_resp_drop;
    logic                       w_resp_fill;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Dropped responses still occupy memory-side slots, so they count
    // against the request budget together with the allocated entries.
    assign w_occupancy    = {1'b0, r_alloc_cnt_q} + {1'b0, r_drop_cnt_q};
    assign imem_req_valid = rst_n & ~redirect_valid & (w_occupancy < c_DEPTH_SUM);
    assign imem_req_addr  = {r_pc_q[31:2], 2'b00};

    assign id_valid = r_buf_fill_q[r_head_ptr_q];
    assign id_pc    = r_buf_pc_q[r_head_ptr_q];
    assign id_instr = r_buf_instr_q[r_head_ptr_q];

    assign w_accept    = imem_req_valid & imem_req_ready;
    assign w_pop       = id_valid & id_ready & ~redirect_valid;
    assign w_resp_drop = imem_resp_valid & (r_drop_cnt_q != '0);
    // A response with nothing pending and nothing to drop is ignored.
    assign w_resp_fill = imem_resp_valid & (r_drop_cnt_q == '0) & (r_pend_cnt_q != '0);

    // Never exceeds DEPTH, so it fits in the counter width.
    assign w_outstanding = r_drop_cnt_q + r_pend_cnt_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_d        = r_pc_q;
        w_buf_pc_d    = r_buf_pc_q;
        w_buf_instr_d = r_buf_instr_q;
        w_buf_fill_d  = r_buf_fill_q;
        w_alloc_ptr_d = r_alloc_ptr_q;
        w_fill_ptr_d  = r_fill_ptr_q;
        w_head_ptr_d  = r_head_ptr_q;
        w_alloc_cnt_d = r_alloc_cnt_q;
        w_pend_cnt_d  = r_pend_cnt_q;
        w_drop_cnt_d  = r_drop_cnt_q;

        if (redirect_valid) begin
            // Flush: every unfilled entry becomes a response to discard.
            // A response arriving right now is itself discarded, which
            // retires one of those owed responses immediately.
            w_pc_d        = redirect_target & ~32'h0000_0003;
            w_buf_fill_d  = '0;
            w_alloc_ptr_d = '0;
            w_fill_ptr_d  = '0;
            w_head_ptr_d  = '0;
            w_alloc_cnt_d = '0;
            w_pend_cnt_d  = '0;
            if (imem_resp_valid && (w_outstanding != '0)) begin
                w_drop_cnt_d = w_outstanding - c_CNT_W'(1);
            end else begin
                w_drop_cnt_d = w_outstanding;
            end
        end else begin
            if (w_resp_drop) begin
                w_drop_cnt_d = r_drop_cnt_q - c_CNT_W'(1);
            end

            if (w_resp_fill) begin
                w_buf_instr_d[r_fill_ptr_q] = imem_resp_data;
                w_buf_fill_d[r_fill_ptr_q]  = 1'b1;
                w_fill_ptr_d                = r_fill_ptr_q + c_PTR_W'(1);
            end

            if (w_pop) begin
                w_buf_fill_d[r_head_ptr_q]  = 1'b0;
                w_buf_pc_d[r_head_ptr_q]    = '0;
                w_buf_instr_d[r_head_ptr_q] = '0;
                w_head_ptr_d                = r_head_ptr_q + c_PTR_W'(1);
            end

            // The slot at alloc_ptr is always free here, so it cannot
            // collide with the fill or pop slot written above.
            if (w_accept) begin
                w_buf_pc_d[r_alloc_ptr_q]   = r_pc_q;
                w_buf_fill_d[r_alloc_ptr_q] = 1'b0;
                w_alloc_ptr_d               = r_alloc_ptr_q + c_PTR_W'(1);
                w_pc_d                      = r_pc_q + 32'd4;
            end

            case ({w_accept, w_pop})
                2'b10:   w_alloc_cnt_d = r_alloc_cnt_q + c_CNT_W'(1);
                2'b01:   w_alloc_cnt_d = r_alloc_cnt_q - c_CNT_W'(1);
                default: w_alloc_cnt_d = r_alloc_cnt_q;
            endcase

            case ({w_accept, w_resp_fill})
                2'b10:   w_pend_cnt_d = r_pend_cnt_q + c_CNT_W'(1);
                2'b01:   w_pend_cnt_d = r_pend_cnt_q - c_CNT_W'(1);
                default: w_pend_cnt_d = r_pend_cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_q        <= RESET_PC;
            r_buf_pc_q    <= '0;
            r_buf_instr_q <= '0;
            r_buf_fill_q  <= '0;
            r_alloc_ptr_q <= '0;
            r_fill_ptr_q  <= '0;
            r_head_ptr_q  <= '0;
            r_alloc_cnt_q <= '0;
            r_pend_cnt_q  <= '0;
            r_drop_cnt_q  <= '0;
        end else begin
            r_pc_q        <= w_pc_d;
            r_buf_pc_q    <= w_buf_pc_d;
            r_buf_instr_q <= w_buf_instr_d;
            r_buf_fill_q  <= w_buf_fill_d;
            r_alloc_ptr_q <= w_alloc_ptr_d;
            r_fill_ptr_q  <= w_fill_ptr_d;
            r_head_ptr_q  <= w_head_ptr_d;
            r_alloc_cnt_q <= w_alloc_cnt_d;
            r_pend_cnt_q  <= w_pend_cnt_d;
            r_drop_cnt_q  <= w_drop_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side counterpart of the next-PC incrementer: owns the architectural PC register, issues instruction-memory read requests at PC, PC+4, PC+8, …, and collects the in-order responses.
- Responses are buffered and delivered as {pc, instr} to the decode stage through a valid/ready handshake.
- Handles decode back-pressure and branch/jump redirects from EX, including discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- DEPTH, 4, fetch-buffer entries (power of two, ≥2); also the maximum in-flight plus buffered fetches.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  fetch address, word aligned.
- imem_resp_valid  input  1  response valid; in order; latency ≥1 cycle after acceptance.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  EX redirect strobe.
- redirect_target  input  32  new PC; bits [1:0] ignored.
- id_ready  input  1  decode accepts output this cycle.
- id_valid  output  1  head entry holds instruction.
- id_pc  output  32  PC of head instruction.
- id_instr  output  32  head instruction.

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC; buffer empty; alloc_cnt=0; drop_cnt=0. Outputs after reset: imem_req_valid=0 during the reset cycle then as below, id_valid=0, id_pc=0, id_instr=0. Reset mid-operation discards everything, including later responses to pre-reset requests (memory is reset alongside).
- Buffer: circular queue, DEPTH entries of {pc[31:0], instr[31:0], filled}. Pointers are alloc_ptr, fill_ptr and head_ptr; alloc_cnt is the number of allocated entries.
- Request: imem_req_valid = rst_n & ~redirect_valid & (alloc_cnt + drop_cnt < DEPTH). imem_req_addr = {pc[31:2],2'b00}.
- Request acceptance (valid & ready): allocate entry at alloc_ptr with pc and filled=0; pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC→0).
- Response: if drop_cnt>0, discard and drop_cnt-=1. Else write instr into the entry at fill_ptr, set filled, advance fill_ptr.
- Output: id_valid = head entry filled; id_pc/id_instr = head contents (combinational from buffer).
  - Pop when id_valid & id_ready: clear entry, advance head_ptr, alloc_cnt-=1.
  - Output values hold stable while id_valid & ~id_ready.
  - Allocate and pop in the same cycle leaves alloc_cnt unchanged.
  - A response may fill the head entry and that entry is visible the next cycle (1-cycle response→id_valid latency, no bypass).
- Redirect (redirect_valid=1, priority over everything):
  - pc <= {redirect_target[31:2],2'b00}.
  - Buffer flushed: all pointers=0, alloc_cnt=0, all filled=0.
  - No request issued this cycle (req_valid forced 0).
  - No pop this cycle: id_ready ignored, entry dropped.
  - drop_cnt <= drop_cnt + (unfilled allocated entries) − (imem_resp_valid ? 1 : 0); a response arriving in the redirect cycle is itself discarded.
  - id_valid=0 in the following cycle; the first new request issues the cycle after the redirect.
- Back-to-back redirects: each recomputes drop_cnt by the same rule; the last target wins.
- Full: alloc_cnt+drop_cnt==DEPTH → req_valid=0 until a pop or a discarded response.
- Memory stall (req_ready=0): request held with addr stable (pc unchanged) until accepted or a redirect occurs.
- Invariant: alloc_cnt ≤ DEPTH; drop_cnt ≤ DEPTH. A response arriving with no unfilled entry and drop_cnt=0 is a protocol error and is ignored (assertion in bench).

Test Plan:
- Reset, req_ready=1, 1-cycle memory, id_ready=1 → addrs 3000,3004,3008…; id stream pc 3000/instr M[3000], one instr per cycle after 3-cycle fill.
- id_ready=0 for 10 cycles → exactly DEPTH=4 requests (3000–300C) issued then req_valid=0; id_pc holds 3000; release → 3000,3004,3008,300C in order, fetch resumes at 3010.
- Redirect to 32'h0000_4003 while 2 requests in flight → both responses discarded, next req addr 4000, first id_pc=4000, no 300x instr delivered after redirect.
- Redirect coincident with imem_resp_valid and id_valid&id_ready → that response and head both dropped, drop_cnt = in-flight−1, stream restarts cleanly at target.
- RESET_PC=32'hFFFF_FFF8 → addrs FFFFFFF8, FFFFFFFC, 00000000 (wrap).
- req_ready toggling randomly plus 3-cycle response latency and random id_ready, rst_n pulsed low mid-stream → id_valid=0 next cycle, fetch restarts at RESET_PC, output sequence always consecutive PCs with matching memory data.
